// File: rtl/dac_feeder_pkg.sv
// rtl/dac_feeder_pkg.sv - shared types and constants for the DAC sample feeder
package dac_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int OUT_LANES = 5;
  localparam int DW_DEF = 14;
  localparam logic [DW_DEF-1:0] IDLE_CODE_DEF = 14'h2000;

  typedef logic [DW_DEF-1:0] sample_t;

endpackage

// File: rtl/sample_gearbox.sv
// rtl/sample_gearbox.sv - sample buffer that removes the oldest OUT_LANES samples
// and appends an IN_LANES beat behind the residual in the same edge.
module sample_gearbox
  import dac_feeder_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int IN_LANES  = 8,
  parameter int BUF_DEPTH = 16,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic                              append_i,
  input  logic                              consume_i,
  input  logic [IN_LANES-1:0][DW-1:0]       in_data_i,
  output logic [CW-1:0]                     count_o,
  output logic [OUT_LANES-1:0][DW-1:0]      head_o
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int LW = $clog2(IN_LANES);

  logic [DW-1:0] buf_q [BUF_DEPTH];
  logic [DW-1:0] buf_d [BUF_DEPTH];
  logic [CW-1:0] count_q, count_d;
  int            rem;

  always_comb begin
    rem = int'(count_q) - (consume_i ? OUT_LANES : 0);
    for (int p = 0; p < BUF_DEPTH; p++) begin
      buf_d[p] = buf_q[p];
      if (p < rem) begin
        // residual slides to the front; the modulo only keeps the index in range
        if (consume_i) buf_d[p] = buf_q[AW'((p + OUT_LANES) % BUF_DEPTH)];
      end else if (append_i && (p - rem) < IN_LANES) begin
        buf_d[p] = in_data_i[LW'(p - rem)];
      end
    end
    count_d = CW'(rem + (append_i ? IN_LANES : 0));
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  always_comb begin
    for (int i = 0; i < OUT_LANES; i++) head_o[i] = buf_q[i];
  end

  assign count_o = count_q;

endmodule

// File: rtl/dac_sample_feeder.sv
// rtl/dac_sample_feeder.sv - 8-to-5 sample feeder for the DAC interface with
// priming, idle-code underflow substitution and a ramp bring-up pattern.
module dac_sample_feeder
  import dac_feeder_pkg::*;
#(
  parameter int            DW          = DW_DEF,
  parameter int            IN_LANES    = 8,
  parameter int            BUF_DEPTH   = 16,
  parameter int            START_LEVEL = 10,
  parameter logic [DW-1:0] IDLE_CODE   = IDLE_CODE_DEF
) (
  input  logic                         sysclk_in,
  input  logic                         sys_reset,
  input  logic                         enable,
  input  logic                         pattern_sel,
  input  logic [IN_LANES*DW-1:0]       s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic [OUT_LANES-1:0][DW-1:0] data_out,
  output logic                         running,
  output logic                         underflow,
  output logic [15:0]                  underflow_cnt
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] START_C = CW'(START_LEVEL);
  localparam logic [CW-1:0] OUT_C   = CW'(OUT_LANES);

  state_t                       state_q, state_d;
  logic                         ramp_q, ramp_d;
  logic [DW-1:0]                base_q, base_d;
  logic [OUT_LANES-1:0][DW-1:0] data_q, data_d;
  logic                         uf_q, uf_d;
  logic [15:0]                  ucnt_q, ucnt_d;

  logic [CW-1:0]                count;
  logic [OUT_LANES-1:0][DW-1:0] head;
  logic                         stream_run, consume, room, append, flush;
  int                           level_after;

  // Ready depends on registered state only, so it never waits on s_valid.
  always_comb begin
    stream_run  = (state_q == ST_RUN) && !ramp_q;
    consume     = stream_run && (count >= OUT_C);
    level_after = int'(count) - (consume ? OUT_LANES : 0) + IN_LANES;
    room        = level_after <= BUF_DEPTH;
    s_ready     = ((state_q == ST_PRIME) || stream_run) && room;
  end

  assign append = s_valid && s_ready;
  assign flush  = !enable || (state_q == ST_IDLE);

  sample_gearbox #(
    .DW        (DW),
    .IN_LANES  (IN_LANES),
    .BUF_DEPTH (BUF_DEPTH),
    .CW        (CW)
  ) u_gearbox (
    .clk_i     (sysclk_in),
    .rst_i     (sys_reset),
    .flush_i   (flush),
    .append_i  (append),
    .consume_i (consume),
    .in_data_i (s_data),
    .count_o   (count),
    .head_o    (head)
  );

  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    base_d  = base_q;
    uf_d    = uf_q;
    ucnt_d  = ucnt_q;
    data_d  = {OUT_LANES{IDLE_CODE}};
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = pattern_sel ? ST_RUN : ST_PRIME;
          ramp_d  = pattern_sel;
          base_d  = '0;
          uf_d    = 1'b0;
          ucnt_d  = '0;
        end
        ST_PRIME: begin
          if (count >= START_C) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (ramp_q) begin
            for (int i = 0; i < OUT_LANES; i++) data_d[i] = base_q + DW'(i);
            base_d = base_q + DW'(OUT_LANES);
          end else if (consume) begin
            data_d = head;
          end else begin
            uf_d = 1'b1;
            if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk_in) begin
    if (sys_reset) begin
      state_q <= ST_IDLE;
      ramp_q  <= 1'b0;
      base_q  <= '0;
      data_q  <= {OUT_LANES{IDLE_CODE}};
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      base_q  <= base_d;
      data_q  <= data_d;
      uf_q    <= uf_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign data_out      = data_q;
  assign running       = (state_q == ST_RUN);
  assign underflow     = uf_q;
  assign underflow_cnt = ucnt_q;

endmodule
